// File: rtl/ir_line_sensor_filter_pkg.sv
// Shared constants for the infrared line-sensor array.
//   IR_N_CH              number of physical sensor channels on the board
//   IR_R .. IR_L         channel index constants, bit 0 = rightmost sensor
//   IR_DEBOUNCE_DEFAULT  default persistence count (10 us at a 100 MHz clk)
package ir_line_sensor_filter_pkg;

  localparam int IR_N_CH = 5;

  localparam int IR_R  = 0;
  localparam int IR_RC = 1;
  localparam int IR_C  = 2;
  localparam int IR_LC = 3;
  localparam int IR_L  = 4;

  localparam int IR_DEBOUNCE_DEFAULT = 1000;

endpackage

// File: rtl/ir_line_sensor_filter_debounce_ch.sv
// One sensor channel: synchroniser chain, optional polarity inversion and a
// persistence-count debouncer.
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   raw      raw asynchronous pad input
//   dir      debounced, polarity-corrected level
//   changed  one-cycle pulse in the first cycle dir shows a new value
module ir_debounce_ch #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 1000,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic dir,
  output logic changed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dir_q, dir_d;
  logic                   changed_q, changed_d;
  logic                   smp;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], raw ^ ACTIVE_LOW};
    smp       = sync_q[SYNC_STAGES-1];
    cnt_d     = '0;
    dir_d     = dir_q;
    changed_d = 1'b0;
    // A sample equal to dir leaves cnt_d at 0, which also discards the
    // progress of any glitch that returned before the threshold.
    if (smp != dir_q) begin
      if (cnt_q == CNT_LAST) begin
        dir_d     = smp;
        changed_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the synchroniser flops are reset as well, so a pad level
  // held during reset cannot leak into dir right after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      changed_q <= changed_d;
    end
  end

  assign dir     = dir_q;
  assign changed = changed_q;

endmodule

// File: rtl/ir_line_sensor_filter.sv
// Infrared line-sensor conditioning: per-channel sync + debounce, derived line
// status and a maskable sticky change interrupt.
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   s_raw      raw sensor pads (asynchronous), bit 0 = rightmost
//   irq_mask   per-channel interrupt enable
//   irq_clr    one-cycle pulse clearing irq_pend
//   dir        debounced, polarity-corrected sensor state
//   changed    one-cycle pulse per channel whose dir bit updated
//   n_active   number of set dir bits
//   line_lost  no sensor sees the line
//   crossing   every sensor sees the line
//   irq_pend   sticky masked change flags
//   irq        any pending flag
module ir_line_sensor_filter
  import ir_line_sensor_filter_pkg::*;
#(
  parameter int N_CH         = IR_N_CH,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = IR_DEBOUNCE_DEFAULT,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CH-1:0]           s_raw,
  input  logic [N_CH-1:0]           irq_mask,
  input  logic                      irq_clr,
  output logic [N_CH-1:0]           dir,
  output logic [N_CH-1:0]           changed,
  output logic [$clog2(N_CH+1)-1:0] n_active,
  output logic                      line_lost,
  output logic                      crossing,
  output logic [N_CH-1:0]           irq_pend,
  output logic                      irq
);

  localparam int NA_W = $clog2(N_CH + 1);

  logic [N_CH-1:0] irq_pend_q, irq_pend_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ir_debounce_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw     (s_raw[i]),
      .dir     (dir[i]),
      .changed (changed[i])
    );
  end

  always_comb begin
    n_active = '0;
    for (int i = 0; i < N_CH; i++) begin
      n_active = n_active + NA_W'(dir[i]);
    end
  end

  assign line_lost = (dir == '0);
  assign crossing  = &dir;

  // Clear first, then OR in new events, so a change wins over a same-cycle
  // clear. The mask gates only new events; existing pending bits are kept.
  always_comb begin
    irq_pend_d = irq_pend_q;
    if (irq_clr) begin
      irq_pend_d = '0;
    end
    irq_pend_d = irq_pend_d | (changed & irq_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_pend_q <= '0;
    end else begin
      irq_pend_q <= irq_pend_d;
    end
  end

  assign irq_pend = irq_pend_q;
  assign irq      = |irq_pend_q;

endmodule

// File: tb/tb_ir_line_sensor_filter.sv
module tb_ir_line_sensor_filter;
  import ir_line_sensor_filter_pkg::*;

  typedef struct {
    logic [4:0] dir;
    logic [4:0] changed;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [4:0] s_raw;
  logic [4:0] irq_mask;
  logic       irq_clr;
  logic [4:0] dir;
  logic [4:0] changed;
  logic [2:0] n_active;
  logic       line_lost;
  logic       crossing;
  logic [4:0] irq_pend;
  logic       irq;

  // Second build with inverted pad polarity.
  logic       rst_n_al;
  logic [4:0] s_raw_al;
  logic [4:0] dir_al;
  logic [4:0] changed_al;
  logic [2:0] n_active_al;
  logic       line_lost_al;
  logic       crossing_al;
  logic [4:0] irq_pend_al;
  logic       irq_al;

  int total = 0;
  int bad   = 0;

  exp_t exp_q[$];
  exp_t exp_e;

  ir_line_sensor_filter #(
    .N_CH(IR_N_CH), .SYNC_STAGES(2), .DEBOUNCE_CYC(4), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_raw(s_raw), .irq_mask(irq_mask),
    .irq_clr(irq_clr), .dir(dir), .changed(changed), .n_active(n_active),
    .line_lost(line_lost), .crossing(crossing), .irq_pend(irq_pend), .irq(irq)
  );

  ir_line_sensor_filter #(
    .N_CH(IR_N_CH), .SYNC_STAGES(2), .DEBOUNCE_CYC(4), .ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk(clk), .rst_n(rst_n_al), .s_raw(s_raw_al), .irq_mask(5'b00000),
    .irq_clr(1'b0), .dir(dir_al), .changed(changed_al), .n_active(n_active_al),
    .line_lost(line_lost_al), .crossing(crossing_al), .irq_pend(irq_pend_al),
    .irq(irq_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard: every changed pulse from the main DUT must match the next
  // expected (dir, changed) pair queued when the stimulus was applied.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && changed !== 5'b00000) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: dir=%b changed=%b, required no change pulse", dir, changed);
      end else begin
        exp_e = exp_q.pop_front();
        if (dir !== exp_e.dir || changed !== exp_e.changed) begin
          bad++;
          $display("FAIL sb_event: dir=%b changed=%b, required dir=%b changed=%b",
                   dir, changed, exp_e.dir, exp_e.changed);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n    = 1'b0;
    rst_n_al = 1'b0;
    s_raw    = 5'b11111;
    s_raw_al = 5'b11111;
    irq_mask = 5'b00000;
    irq_clr  = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (dir !== 5'b00000) begin bad++; $display("FAIL reset_dir: got %b want %b", dir, 5'b00000); end
    total++; if (line_lost !== 1'b1) begin bad++; $display("FAIL reset_line_lost: got %b want 1", line_lost); end
    total++; if (irq !== 1'b0 || irq_pend !== 5'b00000) begin bad++; $display("FAIL reset_irq: got irq=%b pend=%b want 0/00000", irq, irq_pend); end
    total++; if (n_active !== 3'd0 || crossing !== 1'b0) begin bad++; $display("FAIL reset_status: got n_active=%0d crossing=%b want 0/0", n_active, crossing); end
    s_raw = 5'b00000;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (dir !== 5'b00000 || changed !== 5'b00000) begin bad++; $display("FAIL reset_release: got dir=%b changed=%b want 00000/00000", dir, changed); end
  endtask

  task automatic test_step();
    irq_mask = 5'b11111;
    exp_q.push_back('{dir: 5'b00100, changed: 5'b00100});
    s_raw = 5'b00100;
    repeat (5) @(negedge clk);
    total++; if (dir !== 5'b00000) begin bad++; $display("FAIL step_early: got %b want %b", dir, 5'b00000); end
    @(negedge clk);
    total++; if (dir !== 5'b00100) begin bad++; $display("FAIL step_dir: got %b want %b", dir, 5'b00100); end
    total++; if (changed !== 5'b00100) begin bad++; $display("FAIL step_changed: got %b want %b", changed, 5'b00100); end
    total++; if (n_active !== 3'd1) begin bad++; $display("FAIL step_n_active: got %0d want 1", n_active); end
    @(negedge clk);
    total++; if (changed !== 5'b00000) begin bad++; $display("FAIL step_pulse_len: got %b want %b", changed, 5'b00000); end
    total++; if (irq_pend !== 5'b00100 || irq !== 1'b1) begin bad++; $display("FAIL step_irq: got pend=%b irq=%b want 00100/1", irq_pend, irq); end
  endtask

  task automatic test_glitch();
    logic seen;
    seen  = 1'b0;
    s_raw = 5'b00101;
    repeat (3) @(negedge clk);
    s_raw = 5'b00100;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | dir[IR_R] | changed[IR_R];
    end
    total++; if (seen !== 1'b0 || dir !== 5'b00100) begin bad++; $display("FAIL glitch: got seen=%b dir=%b want 0/00100", seen, dir); end
  endtask

  // A pulse lasting exactly DEBOUNCE_CYC samples is accepted, then undone.
  task automatic test_threshold();
    exp_q.push_back('{dir: 5'b00101, changed: 5'b00001});
    exp_q.push_back('{dir: 5'b00100, changed: 5'b00001});
    s_raw = 5'b00101;
    repeat (4) @(negedge clk);
    s_raw = 5'b00100;
    repeat (14) @(negedge clk);
    total++; if (dir !== 5'b00100) begin bad++; $display("FAIL threshold_dir: got %b want %b", dir, 5'b00100); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL threshold_events: got %0d outstanding want 0", exp_q.size()); end
  endtask

  task automatic test_crossing();
    exp_q.push_back('{dir: 5'b11111, changed: 5'b11011});
    s_raw = 5'b11111;
    repeat (6) @(negedge clk);
    total++; if (crossing !== 1'b1 || n_active !== 3'd5 || line_lost !== 1'b0) begin bad++; $display("FAIL crossing_on: got crossing=%b n_active=%0d lost=%b want 1/5/0", crossing, n_active, line_lost); end
    exp_q.push_back('{dir: 5'b00000, changed: 5'b11111});
    s_raw = 5'b00000;
    repeat (6) @(negedge clk);
    total++; if (line_lost !== 1'b1 || crossing !== 1'b0 || n_active !== 3'd0) begin bad++; $display("FAIL crossing_off: got lost=%b crossing=%b n_active=%0d want 1/0/0", line_lost, crossing, n_active); end
  endtask

  task automatic test_irq_race();
    irq_mask = 5'b11111;
    @(negedge clk);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    total++; if (irq_pend !== 5'b00000) begin bad++; $display("FAIL irq_preclear: got %b want %b", irq_pend, 5'b00000); end
    exp_q.push_back('{dir: 5'b00010, changed: 5'b00010});
    s_raw = 5'b00010;
    repeat (6) @(negedge clk);
    total++; if (changed !== 5'b00010) begin bad++; $display("FAIL irq_race_changed: got %b want %b", changed, 5'b00010); end
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    total++; if (irq_pend !== 5'b00010 || irq !== 1'b1) begin bad++; $display("FAIL irq_set_wins: got pend=%b irq=%b want 00010/1", irq_pend, irq); end
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    total++; if (irq_pend !== 5'b00000 || irq !== 1'b0) begin bad++; $display("FAIL irq_clear: got pend=%b irq=%b want 00000/0", irq_pend, irq); end
    irq_mask = 5'b11101;
    exp_q.push_back('{dir: 5'b00000, changed: 5'b00010});
    s_raw = 5'b00000;
    repeat (8) @(negedge clk);
    total++; if (dir !== 5'b00000 || irq_pend !== 5'b00000 || irq !== 1'b0) begin bad++; $display("FAIL irq_masked: got dir=%b pend=%b irq=%b want 00000/00000/0", dir, irq_pend, irq); end
  endtask

  task automatic test_active_low();
    s_raw_al = 5'b11111;
    rst_n_al = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (dir_al !== 5'b00000) begin bad++; $display("FAIL al_idle: got %b want %b", dir_al, 5'b00000); end
    s_raw_al = 5'b11011;
    repeat (4) @(negedge clk);
    rst_n_al = 1'b0;
    @(negedge clk);
    rst_n_al = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (dir_al !== 5'b00000) begin bad++; $display("FAIL al_discard: got %b want %b", dir_al, 5'b00000); end
    @(negedge clk);
    total++; if (dir_al !== 5'b00100) begin bad++; $display("FAIL al_dir: got %b want %b", dir_al, 5'b00100); end
    rst_n_al = 1'b0;
    #1;
    total++; if (dir_al !== 5'b00000) begin bad++; $display("FAIL al_reset_async: got %b want %b", dir_al, 5'b00000); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_step();
    test_glitch();
    test_threshold();
    test_crossing();
    test_irq_race();
    test_active_low();
    repeat (2) @(negedge clk);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_drain: got %0d outstanding want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
